ofmap_packer: RTL and testbench

OFMAP_PACKER -- requirements
Module: ofmap_packer

---
 rtl/ofmap_pkg.sv | 21 ++
 rtl/word_fifo.sv | 53 +++++
 rtl/ofmap_packer.sv | 139 +++++++++++++
 tb/tb_ofmap_packer.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ofmap_pkg.sv
// Shared definitions for the output-feature-map packer: FSM states,
// lane count and the byte-lane mask helper.
package ofmap_pkg;

  localparam int LANES = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PACK  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Mask with lanes 0..last_lane enabled (last_lane=3 gives a full word).
  function automatic logic [LANES-1:0] lane_mask(input logic [1:0] last_lane);
    logic [LANES:0] ones;
    ones = (5'b00010 << last_lane) - 5'd1;
    return ones[LANES-1:0];
  endfunction

endpackage

// File: rtl/word_fifo.sv
// Small synchronous FIFO holding packed words. Head is read straight from
// the storage registers, so a pushed word is visible the cycle after the
// push. A push while full is accepted only if the head pops in that cycle.
module word_fifo #(
  parameter int WIDTH = 52,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW:0]      wr_ptr;
  logic [PW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr[PW-1:0]];

  // Pointer update; reset empties the FIFO.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (PW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (PW+1)'(1);
    end
  end

  // Storage write.
  always_ff @(posedge clk) begin
    // NOTE: storage is deliberately not reset; an empty FIFO's contents are
    // never observed because the consumer gates its outputs on !empty.
    if (do_push) mem[wr_ptr[PW-1:0]] <= push_data;
  end

endmodule

// File: rtl/ofmap_packer.sv
// Packs a stream of 8-bit quantized pixels into 32-bit words with byte
// masks and word addresses, queued through a small FIFO toward the
// output buffer. One tile per start pulse.
module ofmap_packer
  import ofmap_pkg::*;
#(
  parameter int ADDR_W     = 16,
  parameter int FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] num_pixels,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              wr_en,
  input  logic              wr_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic [3:0]        wr_mask,
  output logic              busy,
  output logic              done,
  output logic              overflow
);

  localparam int FW = ADDR_W + 36;

  state_t            state;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W-1:0] num_q;
  logic [ADDR_W-1:0] pix_cnt;
  logic [ADDR_W-1:0] word_cnt;
  logic [1:0]        lane_cnt;
  logic [23:0]       lane_buf;

  logic              accept;
  logic              last_pix;
  logic              push;
  logic              pop;
  logic              full;
  logic              empty;
  logic [31:0]       push_word;
  logic [FW-1:0]     push_data;
  logic [FW-1:0]     head;

  // Lanes above lane_cnt in lane_buf are always zero, so OR-ing in the
  // current byte yields a word whose unused lanes are already cleared.
  assign accept    = (state == PACK) && in_valid;
  assign last_pix  = accept && (pix_cnt == num_q - ADDR_W'(1));
  assign push      = accept && ((lane_cnt == 2'd3) || last_pix);
  assign push_word = {8'h00, lane_buf} | ({24'h0, in_data} << {lane_cnt, 3'b000});
  assign push_data = {base_q + word_cnt, push_word, lane_mask(lane_cnt)};
  assign pop       = !empty && wr_ready;

  assign busy = (state == PACK) || (state == DRAIN);
  assign done = (state == DONE);

  word_fifo #(
    .WIDTH(FW),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_data(push_data),
    .pop      (pop),
    .head     (head),
    .full     (full),
    .empty    (empty)
  );

  // Present the FIFO head, forced to zero while the FIFO is empty.
  always_comb begin
    // NOTE: defaults first so every path assigns every output (no latches).
    wr_en   = !empty;
    wr_addr = '0;
    wr_data = '0;
    wr_mask = '0;
    if (!empty) {wr_addr, wr_data, wr_mask} = head;
  end

  // Tile FSM with pixel, lane and word counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      base_q   <= '0;
      num_q    <= '0;
      pix_cnt  <= '0;
      word_cnt <= '0;
      lane_cnt <= '0;
      lane_buf <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            base_q   <= base_addr;
            num_q    <= num_pixels;
            pix_cnt  <= '0;
            word_cnt <= '0;
            lane_cnt <= '0;
            lane_buf <= '0;
            state    <= (num_pixels == '0) ? DONE : PACK;
          end
        end
        PACK: begin
          if (accept) begin
            pix_cnt <= pix_cnt + ADDR_W'(1);
            if (push) begin
              lane_cnt <= '0;
              lane_buf <= '0;
              word_cnt <= word_cnt + ADDR_W'(1);
            end else begin
              lane_cnt <= lane_cnt + 2'd1;
              lane_buf <= push_word[23:0];
            end
            if (last_pix) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (empty) state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Sticky overflow: set when a word is dropped, cleared by an accepted start.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if ((state == IDLE) && start) begin
      overflow <= 1'b0;
    end else if (push && full && !pop) begin
      overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ofmap_packer.sv
// Directed bench for ofmap_packer: drives tiles and checks the written
// words, done pulses, overflow and reset behaviour against constants.
module tb_ofmap_packer;

  localparam int AW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW-1:0] num_pixels;
  logic          in_valid;
  logic [7:0]    in_data;
  logic          wr_en;
  logic          wr_ready;
  logic [AW-1:0] wr_addr;
  logic [31:0]   wr_data;
  logic [3:0]    wr_mask;
  logic          busy;
  logic          done;
  logic          overflow;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
    logic [3:0]    mask;
  } wr_t;

  wr_t wq[$];
  int  done_cnt     = 0;
  int  cyc          = 0;
  int  last_wr_cyc  = 0;
  int  done_cyc     = 0;
  int  n_cmp        = 0;
  int  n_err        = 0;

  ofmap_packer dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .num_pixels(num_pixels),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .wr_en     (wr_en),
    .wr_ready  (wr_ready),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_mask   (wr_mask),
    .busy      (busy),
    .done      (done),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  // Passive monitor: records accepted writes and done pulses mid-cycle.
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (wr_en && wr_ready) begin
      wq.push_back({wr_addr, wr_data, wr_mask});
      last_wr_cyc <= cyc;
    end
    if (done) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_wr(input string tag, input int idx, input logic [AW-1:0] addr,
                        input logic [31:0] data, input logic [3:0] mask);
    wr_t got;
    got = (idx < wq.size()) ? wq[idx] : 'x;
    chk(tag, 64'(got), 64'({addr, data, mask}));
  endtask

  function automatic logic [63:0] all_outs();
    return 64'({wr_en, wr_addr, wr_data, wr_mask, busy, done, overflow});
  endfunction

  // One tile: a stray byte in IDLE, the start pulse, then num consecutive
  // bytes b0, b0+1, ...; optionally a start pulse mid-tile that must be ignored.
  task automatic run_tile(input logic [AW-1:0] base, input logic [AW-1:0] num,
                          input logic [7:0] b0, input bit glitch);
    in_valid = 1'b1;
    in_data  = 8'hEE;
    step();
    in_valid   = 1'b0;
    start      = 1'b1;
    base_addr  = base;
    num_pixels = num;
    step();
    start      = 1'b0;
    base_addr  = '0;
    num_pixels = '0;
    for (int i = 0; i < int'(num); i++) begin
      in_valid = 1'b1;
      in_data  = 8'(b0 + 8'(i));
      if (glitch && i == 2) begin
        start      = 1'b1;
        base_addr  = 16'h7777;
        num_pixels = 16'd1;
      end
      step();
      start = 1'b0;
    end
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int d0;
    int done_seen;
    int done_idx;
    bit busy_seen;
    bit wr_seen;

    rst        = 1'b1;
    start      = 1'b0;
    base_addr  = '0;
    num_pixels = '0;
    in_valid   = 1'b0;
    in_data    = '0;
    wr_ready   = 1'b1;

    // Reset values, during reset and the cycle after.
    step();
    step();
    chk("reset_outs", all_outs(), 64'h0);
    rst = 1'b0;
    step();
    chk("post_reset_outs", all_outs(), 64'h0);

    // Two full words at 0x0100.
    wq.delete();
    d0 = done_cnt;
    run_tile(16'h0100, 16'd8, 8'h01, 1'b0);
    chk("t1_busy", 64'(busy), 64'h1);
    idle(12);
    chk("t1_nwr", 64'(wq.size()), 64'd2);
    chk_wr("t1_w0", 0, 16'h0100, 32'h04030201, 4'hF);
    chk_wr("t1_w1", 1, 16'h0101, 32'h08070605, 4'hF);
    chk("t1_done_cnt", 64'(done_cnt - d0), 64'd1);
    chk("t1_done_after_wr", 64'(done_cyc > last_wr_cyc), 64'd1);
    chk("t1_idle", 64'({busy, wr_en}), 64'h0);

    // Partial final word; a start pulse mid-tile is ignored.
    wq.delete();
    d0 = done_cnt;
    run_tile(16'h0020, 16'd6, 8'hA0, 1'b1);
    idle(12);
    chk("t2_nwr", 64'(wq.size()), 64'd2);
    chk_wr("t2_w0", 0, 16'h0020, 32'hA3A2A1A0, 4'hF);
    chk_wr("t2_w1", 1, 16'h0021, 32'h0000A5A4, 4'b0011);
    chk("t2_done_cnt", 64'(done_cnt - d0), 64'd1);

    // Empty tile: no writes, never busy, a single done shortly after start.
    wq.delete();
    done_seen = 0;
    done_idx  = -1;
    busy_seen = 1'b0;
    wr_seen   = 1'b0;
    start      = 1'b1;
    base_addr  = 16'h0500;
    num_pixels = 16'd0;
    step();
    start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (done) begin
        done_seen++;
        if (done_idx < 0) done_idx = i;
      end
      busy_seen |= busy;
      wr_seen   |= wr_en;
      step();
    end
    chk("t3_done_once", 64'(done_seen), 64'd1);
    chk("t3_done_latency", 64'(done_idx >= 0 && done_idx <= 1), 64'd1);
    chk("t3_no_busy", 64'(busy_seen), 64'd0);
    chk("t3_no_wr", 64'(wr_seen), 64'd0);

    // Stalled consumer: FIFO fills with words 0 and 1, later words dropped.
    wq.delete();
    d0 = done_cnt;
    wr_ready = 1'b0;
    run_tile(16'h0300, 16'd16, 8'h10, 1'b0);
    chk("t4_overflow", 64'(overflow), 64'h1);
    chk("t4_head", 64'({wr_en, wr_addr, wr_data, wr_mask}), 64'({1'b1, 16'h0300, 32'h13121110, 4'hF}));
    idle(3);
    chk("t4_head_stable", 64'({wr_en, wr_addr, wr_data}), 64'({1'b1, 16'h0300, 32'h13121110}));
    chk("t4_busy_drain", 64'(busy), 64'h1);
    chk("t4_no_wr_yet", 64'(wq.size()), 64'd0);
    wr_ready = 1'b1;
    idle(10);
    chk("t4_nwr", 64'(wq.size()), 64'd2);
    chk_wr("t4_w0", 0, 16'h0300, 32'h13121110, 4'hF);
    chk_wr("t4_w1", 1, 16'h0301, 32'h17161514, 4'hF);
    chk("t4_done_cnt", 64'(done_cnt - d0), 64'd1);
    chk("t4_overflow_held", 64'(overflow), 64'h1);

    // Address wrap; the new start also clears overflow.
    wq.delete();
    run_tile(16'hFFFF, 16'd8, 8'h31, 1'b0);
    chk("t5_overflow_cleared", 64'(overflow), 64'h0);
    idle(12);
    chk("t5_nwr", 64'(wq.size()), 64'd2);
    chk_wr("t5_w0", 0, 16'hFFFF, 32'h34333231, 4'hF);
    chk_wr("t5_w1", 1, 16'h0000, 32'h38373635, 4'hF);

    // Reset after 5 of 8 pixels abandons the tile.
    wq.delete();
    d0 = done_cnt;
    start      = 1'b1;
    base_addr  = 16'h0100;
    num_pixels = 16'd8;
    step();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(8'h41 + 8'(i));
      step();
    end
    in_valid = 1'b0;
    rst      = 1'b1;
    step();
    chk("t6_in_reset", all_outs(), 64'h0);
    rst = 1'b0;
    step();
    chk("t6_after_reset", all_outs(), 64'h0);
    idle(10);
    chk("t6_no_done", 64'(done_cnt - d0), 64'd0);
    chk("t6_nwr", 64'(wq.size()), 64'd1);
    chk_wr("t6_w0", 0, 16'h0100, 32'h44434241, 4'hF);

    // Next tile after the abandoned one.
    wq.delete();
    d0 = done_cnt;
    run_tile(16'h0200, 16'd4, 8'h51, 1'b0);
    idle(10);
    chk("t7_nwr", 64'(wq.size()), 64'd1);
    chk_wr("t7_w0", 0, 16'h0200, 32'h54535251, 4'hF);
    chk("t7_done_cnt", 64'(done_cnt - d0), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
